// File: rtl/decoder_onehot_scan.sv
// rtl/decoder_onehot_scan.sv - registered one-hot decoder with direct and dwell-timed scan modes
module decoder_onehot_scan #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    start,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        idx,
    output logic                    busy,
    output logic                    wrap
);

    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_W-1:0]     out_q,   out_d;
    logic [SEL_W-1:0]     idx_q,   idx_d;
    logic                 busy_q,  busy_d;
    logic                 wrap_q,  wrap_d;
    logic [DWELL_W-1:0]   cnt_q,   cnt_d;

    logic [SEL_W-1:0]     idx_inc;
    logic                 idx_last;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    assign idx_inc  = idx_q + 1'b1;
    assign idx_last = (idx_q == {SEL_W{1'b1}});

    // Priority: en=0, then mode=0, then start, then scan advance.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
            out_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else if (!mode) begin
            state_d = DIRECT;
            out_d   = onehot(sel);
            idx_d   = sel;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = SCAN;
            out_d   = onehot('0);
            idx_d   = '0;
            busy_d  = 1'b1;
            cnt_d   = '0;
        end else if (state_q == SCAN) begin
            // A dwell lowered below cnt is reached only after cnt overflows.
            if (cnt_q != dwell) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d  = '0;
                idx_d  = idx_inc;
                out_d  = onehot(idx_inc);
                wrap_d = idx_last;
            end
        end else begin
            state_d = IDLE;
            out_d   = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule

// File: doc/decoder_onehot_scan.md
Name: decoder_onehot_scan

Overview:
Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder. It is the successor to the combinational 3-to-8 decoder.
- Direct mode: out is the registered decode of sel.
- Scan mode: an internal index walks a single hot bit across all outputs. Each position is held for a programmable dwell time. A wrap pulse flags the end of each sweep.
- Intended uses: row/digit select, round-robin channel strobes and test walking-ones.

Parameters:
SEL_W, 3, select width; output width is 2^SEL_W.
DWELL_W, 8, width of the dwell count input and the internal dwell counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  block enable; 0 forces out to all-zero (registered).
mode  input  1  0 = direct decode, 1 = scan.
start  input  1  scan start/restart strobe, sampled when en=1 and mode=1.
sel  input  SEL_W  direct-mode select code.
dwell  input  DWELL_W  scan hold; each position is held dwell+1 cycles.
out  output  2^SEL_W  registered one-hot (or all-zero) decode.
idx  output  SEL_W  index currently driven hot (last decoded value).
busy  output  1  1 while in SCAN state.
wrap  output  1  one-cycle pulse when the scan index wraps from 2^SEL_W-1 to 0.

Behaviour:
- States: IDLE, DIRECT, SCAN. Internal dwell counter cnt is DWELL_W bits wide.
- Reset (async, immediate): state=IDLE, out=0, idx=0, busy=0, wrap=0, cnt=0. Reset mid-scan aborts the scan with no wrap pulse.
- Update priority per clock, highest first: en=0 > mode=0 > start > scan advance.
- en=0: next state IDLE; out<=0, busy<=0, wrap<=0, cnt<=0; idx holds.
- en=1, mode=0: next state DIRECT; out<=1<<sel, idx<=sel, busy<=0, wrap<=0.
  - Latency is 1 cycle: out reflects the sel sampled at the previous edge.
- en=1, mode=1, state IDLE or DIRECT, start=0: next state IDLE; out<=0, busy<=0. idx holds.
- en=1, mode=1, start=1 (any state, including SCAN): next state SCAN; idx<=0, out<=1, cnt<=0, busy<=1, wrap<=0.
  - A start issued during SCAN is a restart and never pulses wrap.
- SCAN advance, with en=1, mode=1, start=0:
  - If cnt != dwell: cnt<=cnt+1; out, idx hold.
  - If cnt == dwell: cnt<=0, idx<=idx+1 (modulo 2^SEL_W), out<=1<<(idx+1).
  - wrap<=1 only when the old idx was 2^SEL_W-1; otherwise wrap<=0.
- dwell is sampled live each cycle; a change takes effect at the next compare.
  - If dwell is lowered below the current cnt, cnt counts up through DWELL_W overflow to reach the new value.
- dwell=0: the hot bit advances every cycle, and wrap pulses once every 2^SEL_W cycles.
- Sweep period: 2^SEL_W*(dwell+1) cycles from the start edge to the first wrap edge.
- Leaving SCAN via mode=0 goes to DIRECT next cycle (out=1<<sel). Leaving via en=0 goes to IDLE (out=0). Neither pulses wrap.
- out is always exactly one-hot or all-zero, never multi-hot. idx never leaves range.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
1. Reset: assert rst asynchronously mid-SCAN with out=8'h10 -> out=0, idx=0, busy=0, wrap=0 immediately, before the next clk edge.
2. Direct sweep (SEL_W=3): en=1, mode=0, sel=0..7 one per cycle.
   -> out=8'h01,02,...,80 each one cycle after its sel. Set sel=5, then drop en -> out=8'h20, then 8'h00 the next cycle.
3. Scan, dwell=2: pulse start -> busy=1 and out=8'h01 for 3 cycles, then 8'h02 for 3 cycles, and so on up to 8'h80.
   -> 24 cycles after the start edge: out=8'h01, idx=0, wrap=1 for exactly that cycle.
4. Scan, dwell=0: out walks 01,02,04,...,80,01 one step per cycle. wrap is high on every 8th cycle only.
5. Restart and exit: with dwell=3, pulse start again while out=8'h08 -> out=8'h01, cnt restarts, wrap stays 0.
   -> Then set mode=0 with sel=6 -> out=8'h40, busy=0 next cycle.
6. Parameter check: SEL_W=4, DWELL_W=4.
   -> Direct sel=15 gives out=16'h8000. A scan with dwell=15 wraps after 256 cycles; out is never multi-hot.
